data_mem_dp: RTL and testbench

DATA_MEM_DP -- requirements
Module: data_mem_dp

---
 rtl/data_mem_dp.sv | 107 ++++++++++
 tb/tb_data_mem_dp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_dp.sv
// rtl/data_mem_dp.sv - word memory with zeroing init sweep, byte-enable writes and registered reads
// Define DATA_MEM_DP_FWD_EN to forward same-address write data into a same-cycle read.
module data_mem_dp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_vld,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wrt_data,
  input  logic [DATA_W/8-1:0] be,
  output logic                rdy,
  output logic                err,
  input  logic                err_clr
);

  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  init_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              r_ok, w_ok;
  logic [IDX_W-1:0]  ridx, widx;
  logic [DATA_W-1:0] rd_word, rd_next;

  assign r_ok = {1'b0, raddr} < DEPTH_A;
  assign w_ok = {1'b0, waddr} < DEPTH_A;
  assign ridx = raddr[IDX_W-1:0];
  assign widx = waddr[IDX_W-1:0];
  assign rdy  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_ptr == LAST) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= INIT;
      init_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_ptr <= init_ptr + IDX_W'(1);
    end
  end

  // Memory has no reset of its own; only the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) begin
        mem[init_ptr] <= '0;
      end else if (we && w_ok) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wrt_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[ridx];
`ifdef DATA_MEM_DP_FWD_EN
    if (we && w_ok && waddr == raddr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) rd_word[8*i +: 8] = wrt_data[8*i +: 8];
      end
    end
`endif
    rd_next = r_ok ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else if (rdy && re) begin
      rd_vld  <= 1'b1;
      rd_data <= rd_next;
    end else begin
      rd_vld  <= 1'b0;
    end
  end

  // A new bad access wins over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (rdy && ((re && !r_ok) || (we && !w_ok))) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_dp.sv
// tb/tb_data_mem_dp.sv - directed self-checking bench for data_mem_dp
module tb_data_mem_dp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we, err_clr;
  logic [15:0] raddr, waddr, wrt_data;
  logic [1:0]  be;
  logic [15:0] rd_data;
  logic        rd_vld, rdy, err;

  int checks = 0;
  int errors = 0;
  int n;
  logic [15:0] exp_fwd, exp_part;
  logic seen_vld, seen_err;

  data_mem_dp dut (
    .clk(clk), .rst_n(rst_n), .re(re), .raddr(raddr), .rd_data(rd_data),
    .rd_vld(rd_vld), .we(we), .waddr(waddr), .wrt_data(wrt_data), .be(be),
    .rdy(rdy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rdy(output int cnt);
    cnt = 0;
    while (rdy !== 1'b1 && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    we = 1'b1; waddr = a; wrt_data = d; be = b;
    tick();
    we = 1'b0; be = 2'b00;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
    check({tag, "_vld"}, 32'(rd_vld), 32'd1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0; err_clr = 1'b0;
    raddr = '0; waddr = '0; wrt_data = '0; be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_vld", 32'(rd_vld), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Requests during INIT must be ignored, including a late write to the already-swept word 0.
    rst_n = 1'b1;
    n = 0; seen_vld = 1'b0; seen_err = 1'b0;
    while (rdy !== 1'b1 && n < 2000) begin
      if (n >= 300 && n < 310) begin
        we = 1'b1; re = 1'b1; be = 2'b11; wrt_data = 16'hFFFF;
        waddr = (n < 305) ? 16'd0 : 16'd600; raddr = 16'd0;
      end else begin
        we = 1'b0; re = 1'b0; be = 2'b00;
      end
      tick();
      n++;
      if (rd_vld) seen_vld = 1'b1;
      if (err) seen_err = 1'b1;
    end
    we = 1'b0; re = 1'b0; be = 2'b00;
    check("init_cycles", 32'(n), 32'd512);
    check("init_no_vld", 32'(seen_vld), 32'd0);
    check("init_no_err", 32'(seen_err), 32'd0);

    rd_chk("rd0", 16'd0, 16'h0000);
    rd_chk("rd511", 16'd511, 16'h0000);

    wr(16'd5, 16'hBEEF, 2'b11);
    wr(16'd5, 16'h12AB, 2'b10);
    rd_chk("be_merge", 16'd5, 16'h12EF);
    tick();
    check("idle_vld", 32'(rd_vld), 32'd0);
    check("hold_data", 32'(rd_data), 32'h12EF);
    wr(16'd5, 16'hFFFF, 2'b00);
    rd_chk("be_zero", 16'd5, 16'h12EF);

    wr(16'd1, 16'h1111, 2'b11);
    wr(16'd2, 16'h2222, 2'b11);
    wr(16'd3, 16'h3333, 2'b11);
    re = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      raddr = 16'(i);
      tick();
      check("b2b_vld", 32'(rd_vld), 32'd1);
      check("b2b_data", 32'(rd_data), 32'(16'(i) * 16'h1111));
    end
    re = 1'b0;

`ifdef DATA_MEM_DP_FWD_EN
    exp_fwd = 16'hAAAA; exp_part = 16'hAA34;
`else
    exp_fwd = 16'h5555; exp_part = 16'hAAAA;
`endif
    wr(16'd7, 16'h5555, 2'b11);
    we = 1'b1; waddr = 16'd7; wrt_data = 16'hAAAA; be = 2'b11; re = 1'b1; raddr = 16'd7;
    tick();
    we = 1'b0; re = 1'b0; be = 2'b00;
    check("same_addr", 32'(rd_data), 32'(exp_fwd));
    rd_chk("same_addr_wr", 16'd7, 16'hAAAA);
    we = 1'b1; waddr = 16'd7; wrt_data = 16'h1234; be = 2'b01; re = 1'b1; raddr = 16'd7;
    tick();
    we = 1'b0; re = 1'b0; be = 2'b00;
    check("same_addr_part", 32'(rd_data), 32'(exp_part));
    rd_chk("part_wr", 16'd7, 16'hAA34);

    we = 1'b1; waddr = 16'd8; wrt_data = 16'h0808; be = 2'b11; re = 1'b1; raddr = 16'd5;
    tick();
    we = 1'b0; re = 1'b0; be = 2'b00;
    check("indep_rd", 32'(rd_data), 32'h12EF);
    rd_chk("indep_wr", 16'd8, 16'h0808);

    rd_chk("oor_rd", 16'd600, 16'h0000);
    check("oor_err", 32'(err), 32'd1);
    wr(16'd600, 16'hFFFF, 2'b11);
    tick();
    check("err_sticky", 32'(err), 32'd1);
    rd_chk("oor_alias", 16'd88, 16'h0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'd0);
    err_clr = 1'b1; re = 1'b1; raddr = 16'd1000;
    tick();
    err_clr = 1'b0; re = 1'b0;
    check("err_clr_bad", 32'(err), 32'd1);

    // Reset in RUN with a read in flight; err is still set from above.
    wr(16'd3, 16'h1234, 2'b11);
    rd_chk("pre_rst", 16'd3, 16'h1234);
    rst_n = 1'b0; re = 1'b1; raddr = 16'd3;
    tick();
    re = 1'b0;
    check("run_rst_vld", 32'(rd_vld), 32'd0);
    check("run_rst_rdy", 32'(rdy), 32'd0);
    check("run_rst_err", 32'(err), 32'd0);
    check("run_rst_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    wait_rdy(n);
    check("run_rst_cycles", 32'(n), 32'd512);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    check("mid_init_rdy", 32'(rdy), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_rdy(n);
    check("init_rst_cycles", 32'(n), 32'd512);
    rd_chk("reinit_rd3", 16'd3, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
